mac_wb_sequencer: RTL and testbench
===================================

Name: mac_wb_sequencer

Overview:
- Wishbone-slave controller that buffers operand pairs in an internal FIFO and sequences the MAC datapath core.
- Streams LEN products into the core, waits out the core's pipeline latency, then captures the accumulator into a readable result register and raises an interrupt.
- Sits between the management SoC Wishbone bus and the MAC core inside the user project.

Parameters:
- BASE_ADR, 32'h3000_0000, register window base; decode on wbs_adr_i[31:8] == BASE_ADR[31:8]
- OP_W, 16, operand width (A and B)
- ACC_W, 32, accumulator width
- DEPTH, 8, operand FIFO depth (power of 2)
- MAC_LAT, 2, cycles from the last mac_en to a valid mac_acc

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_ni  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects (full-word access only; writes with sel != 4'hF are ignored but still acked)
- wbs_adr_i  in  32  address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- mac_a  out  OP_W  operand A to the core
- mac_b  out  OP_W  operand B to the core
- mac_en  out  1  core multiply-accumulate enable
- mac_clr  out  1  core accumulator clear, 1-cycle pulse
- mac_acc  in  ACC_W  core accumulator value
- irq  out  1  level interrupt = DONE & IRQ_EN

Behaviour:
- Reset: all outputs 0, FIFO empty, LEN=0, CTRL=0, STATUS=0, RESULT=0, FSM in IDLE.
- Wishbone:
  - Ack is asserted one cycle after cyc&stb&decode-hit and held for exactly 1 cycle; there is no ack in the cycle following an ack.
  - Write side effects occur in the ack cycle.
  - Off-window addresses get no ack.
  - In-window unmapped offsets are acked and read 0.
- Register map (offset, wbs_adr_i[4:2]):
  - 0x00 CTRL: [0] START (write-1 pulse, reads 0), [1] CLR_ACC, [2] IRQ_EN.
  - 0x04 STATUS: [0] BUSY, [1] DONE (sticky, W1C), [2] FULL, [3] EMPTY, [4] ERR (sticky, W1C), [5] OVF (sticky, W1C), [11:8] FIFO count.
  - 0x08 OPND: write pushes A=dat[OP_W-1:0], B=dat[16+OP_W-1:16]; reads 0.
  - 0x0C LEN: [7:0], read/write; writes are ignored while BUSY.
  - 0x10 RESULT: ACC_W bits, read-only.
- FIFO:
  - A push when full is dropped and sets OVF.
  - Simultaneous push and pop in one cycle: count unchanged, data order preserved.
  - Pushes are allowed while BUSY.
- FSM IDLE:
  - START with LEN != 0 and count >= LEN: clear DONE; go to CLEAR if CLR_ACC=1, else go to RUN.
  - START with LEN=0 or count < LEN: set ERR, stay in IDLE.
  - START while not in IDLE is ignored.
- FSM CLEAR: mac_clr=1 for 1 cycle, then go to RUN.
- FSM RUN:
  - Each cycle: pop the FIFO head onto mac_a/mac_b (registered) with mac_en=1, and decrement the issue counter.
  - Exactly LEN consecutive mac_en cycles are issued, then go to DRAIN.
  - mac_a and mac_b return to 0 when mac_en=0.
- FSM DRAIN:
  - Count MAC_LAT cycles after the last mac_en cycle.
  - On the final count: RESULT <= mac_acc, DONE <= 1, go to IDLE.
- BUSY = (state != IDLE).
- Latency: START write ack to first mac_en is 1 cycle (plus 1 if CLR_ACC). Last mac_en to DONE is MAC_LAT+1 cycles.
- Sticky bits: a W1C write in the same cycle as a hardware set leaves the bit set (set wins).
- Asynchronous reset mid-operation:
  - Immediately returns to the reset state and empties the FIFO.
  - mac_en and mac_clr drop asynchronously.
  - A core accumulator left partially accumulated is not this block's concern; software sets CLR_ACC on the next run.

Test Plan:
- Push (3,4),(5,6),(7,8); LEN=3; CTRL=0x3 → one mac_clr pulse, then 3 consecutive mac_en cycles carrying those pairs in order. With a reference core: RESULT=0x00000062 (98), DONE=1, EMPTY=1.
- Same run with IRQ_EN=1 → irq rises in the DONE cycle. Writing STATUS=0x2 clears DONE and irq in the next cycle.
- LEN=4 with 2 entries pushed, START → ERR=1, no mac_en, BUSY=0. LEN=0 with START → ERR=1.
- Push 9 words with DEPTH=8 → FULL=1, count=8, OVF=1. The 9th word is absent from the subsequent LEN=8 run.
- During a LEN=8 run: push new words, write LEN=2, write START → LEN still reads 8, no second run starts. Pushed words are retained and the count reflects concurrent push/pop.
- Assert wb_rst_ni low mid-RUN → mac_en=0 immediately. After release: STATUS=0x0000_0008 (EMPTY), RESULT=0, irq=0.

Source files
------------

// File: rtl/mac_wb_sequencer.sv
// Wishbone-slave sequencer for the MAC core.
// Buffers operand pairs, streams LEN products, captures the accumulator.
module mac_wb_sequencer #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int OP_W    = 16,
  parameter int ACC_W   = 32,
  parameter int DEPTH   = 8,
  parameter int MAC_LAT = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic [OP_W-1:0]  mac_a,
  output logic [OP_W-1:0]  mac_b,
  output logic             mac_en,
  output logic             mac_clr,
  input  logic [ACC_W-1:0] mac_acc,
  output logic             irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e st_q;

  // Wishbone request capture
  logic       ack_q;
  logic [5:0] off_q;
  logic       we_q;
  logic       sel_q;
  logic [31:0] dat_q;
  logic       hit;
  logic       req;

  assign hit = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign req = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      off_q <= '0;
      we_q  <= 1'b0;
      sel_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      if (req) begin
        off_q <= wbs_adr_i[7:2];
        we_q  <= wbs_we_i;
        sel_q <= &wbs_sel_i;
        dat_q <= wbs_dat_i;
      end
    end
  end

  logic wr;
  logic wr_ctrl;
  logic wr_stat;
  logic wr_opnd;
  logic wr_len;

  assign wr      = ack_q & we_q & sel_q;
  assign wr_ctrl = wr & (off_q == 6'd0);
  assign wr_stat = wr & (off_q == 6'd1);
  assign wr_opnd = wr & (off_q == 6'd2);
  assign wr_len  = wr & (off_q == 6'd3);

  // Operand FIFO
  logic [2*OP_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wp_q;
  logic [AW-1:0]     rp_q;
  logic [CW-1:0]     cnt_q;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [2*OP_W-1:0] head;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = wr_opnd & ~full;
  assign head  = mem_q[rp_q];

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_q[wp_q] <= {dat_q[16+OP_W-1:16], dat_q[OP_W-1:0]};
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Control and status
  logic [7:0]       len_q;
  logic [7:0]       rem_q;
  logic [DW-1:0]    dcnt_q;
  logic             clracc_q;
  logic             irqen_q;
  logic             done_q;
  logic             err_q;
  logic             ovf_q;
  logic [ACC_W-1:0] res_q;
  logic             en_q;
  logic             clr_q;
  logic [OP_W-1:0]  a_q;
  logic [OP_W-1:0]  b_q;

  logic idle;
  logic start;
  logic len_ok;
  logic start_ok;
  logic start_err;
  logic drain_end;
  logic done_d;
  logic err_d;
  logic ovf_d;

  assign idle      = (st_q == S_IDLE);
  assign start     = wr_ctrl & dat_q[0] & idle;
  assign len_ok    = (len_q != '0) && (9'(cnt_q) >= 9'(len_q));
  assign start_ok  = start & len_ok;
  assign start_err = start & ~len_ok;
  assign drain_end = (st_q == S_DRAIN) && (dcnt_q == DW'(MAC_LAT - 1));

  // The CLEAR/RUN entry also issues, so the first product is never delayed
  assign pop = (idle & start_ok & ~dat_q[1])
             | (st_q == S_CLEAR)
             | ((st_q == S_RUN) & (rem_q != '0));

  // Hardware set wins over a simultaneous W1C
  assign done_d = (done_q & ~(wr_stat & dat_q[1]) & ~start_ok) | drain_end;
  assign err_d  = (err_q & ~(wr_stat & dat_q[4])) | start_err;
  assign ovf_d  = (ovf_q & ~(wr_stat & dat_q[5])) | (wr_opnd & full);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      st_q     <= S_IDLE;
      len_q    <= '0;
      rem_q    <= '0;
      dcnt_q   <= '0;
      clracc_q <= 1'b0;
      irqen_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      res_q    <= '0;
      en_q     <= 1'b0;
      clr_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      ovf_q  <= ovf_d;
      en_q   <= pop;
      a_q    <= pop ? head[OP_W-1:0] : '0;
      b_q    <= pop ? head[2*OP_W-1:OP_W] : '0;
      clr_q  <= idle & start_ok & dat_q[1];
      if (wr_ctrl) begin
        clracc_q <= dat_q[1];
        irqen_q  <= dat_q[2];
      end
      if (wr_len && idle) begin
        len_q <= dat_q[7:0];
      end
      unique case (st_q)
        S_IDLE: begin
          if (start_ok) begin
            rem_q <= len_q - 8'd1;
            st_q  <= dat_q[1] ? S_CLEAR : S_RUN;
          end
        end
        S_CLEAR: begin
          st_q <= S_RUN;
        end
        S_RUN: begin
          if (rem_q != '0) begin
            rem_q <= rem_q - 8'd1;
          end else begin
            dcnt_q <= '0;
            st_q   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_end) begin
            res_q <= mac_acc;
            st_q  <= S_IDLE;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  // Read mux
  logic [31:0] status;
  logic [31:0] rdata;

  assign status = {20'b0, 4'(cnt_q), 2'b0, ovf_q, err_q,
                   empty, full, done_q, ~idle};

  always_comb begin
    rdata = '0;
    if (ack_q && !we_q) begin
      case (off_q)
        6'd0:    rdata = {29'b0, irqen_q, clracc_q, 1'b0};
        6'd1:    rdata = status;
        6'd3:    rdata = {24'b0, len_q};
        6'd4:    rdata = 32'(res_q);
        default: rdata = '0;
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdata;
  assign mac_a     = a_q;
  assign mac_b     = b_q;
  assign mac_en    = en_q;
  assign mac_clr   = clr_q;
  assign irq       = done_q & irqen_q;

endmodule

// File: tb/tb_mac_wb_sequencer.sv
// Directed bench for mac_wb_sequencer with a 2-cycle reference MAC core.
// Register vectors come from a table; multi-cycle runs are hand sequences.
module tb_mac_wb_sequencer;

  localparam logic [31:0] B = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = B + 32'h00;
  localparam logic [31:0] A_STAT = B + 32'h04;
  localparam logic [31:0] A_OPND = B + 32'h08;
  localparam logic [31:0] A_LEN  = B + 32'h0C;
  localparam logic [31:0] A_RES  = B + 32'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic        mac_en;
  logic        mac_clr;
  logic [31:0] mac_acc;
  logic        irq;

  int nchk = 0;
  int nerr = 0;
  int cyc_n = 0;

  mac_wb_sequencer dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_o),
    .mac_a    (mac_a),
    .mac_b    (mac_b),
    .mac_en   (mac_en),
    .mac_clr  (mac_clr),
    .mac_acc  (mac_acc),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Reference core: accumulate stage plus one output stage
  logic [31:0] acc_q;
  logic [31:0] acc_p;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      acc_p <= '0;
    end else begin
      if (mac_clr) acc_q <= '0;
      else if (mac_en) acc_q <= acc_q + mac_a * mac_b;
      acc_p <= acc_q;
    end
  end
  assign mac_acc = acc_p;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          c;
  } en_t;
  en_t enq[$];
  int  clrq[$];
  int  irq_cyc = -1;

  always @(negedge clk) begin
    if (mac_en) enq.push_back('{mac_a, mac_b, cyc_n});
    if (mac_clr) clrq.push_back(cyc_n);
    if (irq && irq_cyc < 0) irq_cyc = cyc_n;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic xfer(input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output int ac);
    @(posedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    ac = -1;
    rd = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        rd = dat_o;
        ac = cyc_n;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("ack_seen", 32'(ac >= 0), 32'd1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int ac;
    xfer(1'b1, a, d, 4'hF, rd, ac);
  endtask

  task automatic rdchk(input string nm, input logic [31:0] a,
                       input logic [31:0] exp);
    logic [31:0] rd;
    int ac;
    xfer(1'b0, a, '0, 4'hF, rd, ac);
    chk(nm, rd, exp);
  endtask

  task automatic do_reset();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          w;
    logic [7:0]  off;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp;
    string       nm;
  } vec_t;
  vec_t tv[20];

  initial begin
    logic [31:0] rd;
    int ac;
    int s;
    int n;
    tv[0]  = '{0, 8'h00, 4'hF, 32'h0, 32'h0, "ctrl_rst"};
    tv[1]  = '{0, 8'h04, 4'hF, 32'h0, 32'h8, "status_rst"};
    tv[2]  = '{0, 8'h0C, 4'hF, 32'h0, 32'h0, "len_rst"};
    tv[3]  = '{0, 8'h10, 4'hF, 32'h0, 32'h0, "result_rst"};
    tv[4]  = '{0, 8'h14, 4'hF, 32'h0, 32'h0, "unmapped"};
    tv[5]  = '{1, 8'h0C, 4'hF, 32'h1FF, 32'h0, ""};
    tv[6]  = '{0, 8'h0C, 4'hF, 32'h0, 32'hFF, "len_wr"};
    tv[7]  = '{1, 8'h0C, 4'h3, 32'h5, 32'h0, ""};
    tv[8]  = '{0, 8'h0C, 4'hF, 32'h0, 32'hFF, "len_part_sel"};
    tv[9]  = '{1, 8'h00, 4'hF, 32'h6, 32'h0, ""};
    tv[10] = '{0, 8'h00, 4'hF, 32'h0, 32'h6, "ctrl_rw"};
    tv[11] = '{1, 8'h00, 4'hF, 32'h1, 32'h0, ""};
    tv[12] = '{0, 8'h04, 4'hF, 32'h0, 32'h18, "status_err"};
    tv[13] = '{1, 8'h04, 4'hF, 32'h10, 32'h0, ""};
    tv[14] = '{0, 8'h04, 4'hF, 32'h0, 32'h8, "err_w1c"};
    tv[15] = '{1, 8'h08, 4'hF, 32'h0002_0001, 32'h0, ""};
    tv[16] = '{1, 8'h08, 4'hF, 32'h0004_0003, 32'h0, ""};
    tv[17] = '{0, 8'h04, 4'hF, 32'h0, 32'h200, "status_cnt2"};
    tv[18] = '{0, 8'h08, 4'hF, 32'h0, 32'h0, "opnd_reads0"};
    tv[19] = '{0, 8'h00, 4'hF, 32'h0, 32'h0, "start_reads0"};

    do_reset();
    @(negedge clk);
    chk("rst_en", 32'(mac_en), 0);
    chk("rst_irq", 32'(irq), 0);
    for (int i = 0; i < 20; i++) begin
      xfer(tv[i].w, B + 32'(tv[i].off), tv[i].d, tv[i].s, rd, ac);
      if (!tv[i].w) chk(tv[i].nm, rd, tv[i].exp);
    end

    // Off-window: never acked
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_1000;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack) n++;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("offwin_noack", n, 0);

    // Held strobe: ack, gap, ack
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_LEN;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n = n | (32'(ack) << i);
    end
    cyc = 1'b0; stb = 1'b0;
    chk("ack_pattern", n, 32'b1010);

    // Run with clear: 3*4+5*6+7*8 = 98
    do_reset();
    wr(A_OPND, 32'h0004_0003);
    wr(A_OPND, 32'h0006_0005);
    wr(A_OPND, 32'h0008_0007);
    wr(A_LEN, 32'd3);
    enq.delete();
    clrq.delete();
    xfer(1'b1, A_CTRL, 32'h3, 4'hF, rd, s);
    repeat (12) @(posedge clk);
    chk("clr_pulses", clrq.size(), 1);
    if (clrq.size() == 1) chk("clr_cyc", clrq[0], s + 1);
    chk("en_count", enq.size(), 3);
    if (enq.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("en_a", 32'(enq[i].a), 32'(2 * i + 3));
        chk("en_b", 32'(enq[i].b), 32'(2 * i + 4));
        chk("en_cyc", enq[i].c, s + 2 + i);
      end
    end
    @(negedge clk);
    chk("a_idle0", 32'(mac_a), 0);
    chk("b_idle0", 32'(mac_b), 0);
    rdchk("result98", A_RES, 32'h62);
    rdchk("status_done", A_STAT, 32'h0A);
    rdchk("ctrl_keep", A_CTRL, 32'h2);

    // Same run with IRQ_EN
    wr(A_OPND, 32'h0004_0003);
    wr(A_OPND, 32'h0006_0005);
    wr(A_OPND, 32'h0008_0007);
    enq.delete();
    irq_cyc = -1;
    wr(A_CTRL, 32'h7);
    repeat (12) @(posedge clk);
    #1;
    chk("irq_high", 32'(irq), 1);
    chk("en_count_b", enq.size(), 3);
    if (enq.size() == 3) chk("irq_lat", irq_cyc, enq[2].c + 3);
    rdchk("result98_b", A_RES, 32'h62);
    xfer(1'b1, A_STAT, 32'h2, 4'hF, rd, ac);
    @(negedge clk);
    chk("irq_in_ack", 32'(irq), 1);
    @(negedge clk);
    chk("irq_cleared", 32'(irq), 0);
    rdchk("done_w1c", A_STAT, 32'h08);

    // START errors
    do_reset();
    wr(A_OPND, 32'h0001_0001);
    wr(A_OPND, 32'h0001_0001);
    wr(A_LEN, 32'd4);
    enq.delete();
    wr(A_CTRL, 32'h1);
    repeat (4) @(posedge clk);
    rdchk("err_short", A_STAT, 32'h210);
    wr(A_STAT, 32'h10);
    wr(A_LEN, 32'd0);
    wr(A_CTRL, 32'h1);
    repeat (4) @(posedge clk);
    rdchk("err_len0", A_STAT, 32'h210);
    chk("err_no_en", enq.size(), 0);

    // Overflow and activity during a run
    do_reset();
    for (int i = 1; i <= 9; i++) wr(A_OPND, {16'd2, 16'(i)});
    rdchk("status_full", A_STAT, 32'h824);
    wr(A_STAT, 32'h20);
    rdchk("ovf_w1c", A_STAT, 32'h804);
    wr(A_LEN, 32'd8);
    enq.delete();
    xfer(1'b1, A_CTRL, 32'h3, 4'hF, rd, s);
    wr(A_OPND, 32'h0001_0064);
    wr(A_OPND, 32'h0001_0065);
    wr(A_LEN, 32'd2);
    wr(A_CTRL, 32'h1);
    repeat (20) @(posedge clk);
    chk("run8_count", enq.size(), 8);
    if (enq.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("run8_a", 32'(enq[i].a), 32'(i + 1));
        chk("run8_b", 32'(enq[i].b), 32'd2);
      end
    end
    rdchk("len_locked", A_LEN, 32'd8);
    rdchk("status_run8", A_STAT, 32'h202);
    rdchk("result72", A_RES, 32'h48);

    // Reset mid-RUN
    wr(A_LEN, 32'd2);
    wr(A_CTRL, 32'h7);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mac_en) begin
        n = 1;
        break;
      end
    end
    chk("run_started", n, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("en_async", 32'(mac_en), 0);
    chk("clr_async", 32'(mac_clr), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rdchk("rst_status", A_STAT, 32'h8);
    rdchk("rst_result", A_RES, 32'h0);
    rdchk("rst_len", A_LEN, 32'h0);
    rdchk("rst_ctrl", A_CTRL, 32'h0);
    @(negedge clk);
    chk("rst_irq2", 32'(irq), 0);
    chk("rst_en2", 32'(mac_en), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
